// File: rtl/cic_dec_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cic_dec_ctrl : rate-change, flush and start-up discard controller for a CIC
//                decimation filter.                              Rev 1.0
// ----------------------------------------------------------------------------
module cic_dec_ctrl #(
  parameter int N         = 3,
  parameter int BIN       = 12,
  parameter int BOUT      = 24,
  parameter int R_MAX     = 64,
  parameter int RW        = 7,
  parameter int FLUSH_CYC = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [RW-1:0]   cfg_rate,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  output logic            cfg_err,
  input  logic [BIN-1:0]  s_data,
  input  logic            s_valid,
  output logic            s_ready,
  output logic            cic_clr,
  output logic [RW-1:0]   cic_rate,
  output logic [BIN-1:0]  cic_din,
  output logic            cic_din_valid,
  input  logic [BOUT-1:0] cic_dout,
  input  logic            cic_dout_valid,
  output logic [BOUT-1:0] m_data,
  output logic            m_valid,
  output logic            busy,
  output logic            locked
);

  localparam int FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam int DW = (N > 0) ? $clog2(N + 1) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FLUSH  = 2'd1;
  localparam logic [1:0] S_SETTLE = 2'd2;
  localparam logic [1:0] S_RUN    = 2'd3;

  logic [1:0]      state_q,     state_d;
  logic [RW-1:0]   cic_rate_q,  cic_rate_d;
  logic [FW-1:0]   flush_cnt_q, flush_cnt_d;
  logic [DW-1:0]   disc_cnt_q,  disc_cnt_d;
  logic            cfg_err_q,   cfg_err_d;
  logic [BOUT-1:0] m_data_q,    m_data_d;
  logic            m_valid_q,   m_valid_d;
  logic            cfg_ready_q;
  logic            s_ready_q;
  logic            cic_clr_q;
  logic            busy_q;
  logic            locked_q;

  logic            cfg_acc;
  logic            rate_ok;

  assign cfg_acc = cfg_valid & cfg_ready_q;
  assign rate_ok = (cfg_rate >= RW'(2)) && (cfg_rate <= RW'(R_MAX));

  always_comb begin
    state_d     = state_q;
    cic_rate_d  = cic_rate_q;
    flush_cnt_d = flush_cnt_q;
    disc_cnt_d  = disc_cnt_q;
    cfg_err_d   = 1'b0;
    m_valid_d   = 1'b0;
    m_data_d    = m_data_q;

    case (state_q)
      S_FLUSH: begin
        if (flush_cnt_q == FW'(FLUSH_CYC - 1)) begin
          state_d    = S_SETTLE;
          disc_cnt_d = DW'(N);
        end else begin
          flush_cnt_d = flush_cnt_q + FW'(1);
        end
      end
      S_SETTLE: begin
        // Start-up transient: swallow N strobes, the last one included.
        if (cic_dout_valid) begin
          disc_cnt_d = (disc_cnt_q != '0) ? disc_cnt_q - DW'(1) : '0;
          if (disc_cnt_q <= DW'(1)) begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (cic_dout_valid) begin
          m_valid_d = 1'b1;
          m_data_d  = cic_dout;
        end
      end
      default: ;
    endcase

    // A legal rate request overrides the state progression above; the
    // RUN-state forwarding in the accept cycle is deliberately kept.
    if (cfg_acc) begin
      if (rate_ok) begin
        state_d     = S_FLUSH;
        cic_rate_d  = cfg_rate;
        flush_cnt_d = '0;
      end else begin
        cfg_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cic_rate_q  <= '0;
      flush_cnt_q <= '0;
      disc_cnt_q  <= '0;
      cfg_err_q   <= 1'b0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      cfg_ready_q <= 1'b1;
      s_ready_q   <= 1'b0;
      cic_clr_q   <= 1'b1;
      busy_q      <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cic_rate_q  <= cic_rate_d;
      flush_cnt_q <= flush_cnt_d;
      disc_cnt_q  <= disc_cnt_d;
      cfg_err_q   <= cfg_err_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      // Control outputs are decoded from the next state so they are glitch-free flops.
      cfg_ready_q <= (state_d != S_FLUSH);
      s_ready_q   <= (state_d == S_SETTLE) || (state_d == S_RUN);
      cic_clr_q   <= (state_d == S_IDLE) || (state_d == S_FLUSH);
      busy_q      <= (state_d == S_FLUSH) || (state_d == S_SETTLE);
      locked_q    <= (state_d == S_RUN);
    end
  end

  assign cfg_ready     = cfg_ready_q;
  assign cfg_err       = cfg_err_q;
  assign s_ready       = s_ready_q;
  assign cic_clr       = cic_clr_q;
  assign cic_rate      = cic_rate_q;
  assign cic_din       = s_data;
  assign cic_din_valid = s_valid & s_ready_q;
  assign m_data        = m_data_q;
  assign m_valid       = m_valid_q;
  assign busy          = busy_q;
  assign locked        = locked_q;

endmodule
`default_nettype wire

// File: tb/tb_cic_dec_ctrl.sv
`default_nettype none
// Bench for cic_dec_ctrl: directed config sequence, behavioural CIC in the
// stimulus loop, and a queue of expected forwarded outputs.
module tb_cic_dec_ctrl;

  localparam int N         = 3;
  localparam int BIN       = 12;
  localparam int BOUT      = 24;
  localparam int R_MAX     = 64;
  localparam int RW        = 7;
  localparam int FLUSH_CYC = 4;

  localparam int P_IDLE   = 0;
  localparam int P_FLUSH  = 1;
  localparam int P_SETTLE = 2;
  localparam int P_RUN    = 3;

  logic            clk;
  logic            rst_n;
  logic [RW-1:0]   cfg_rate;
  logic            cfg_valid;
  logic            cfg_ready;
  logic            cfg_err;
  logic [BIN-1:0]  s_data;
  logic            s_valid;
  logic            s_ready;
  logic            cic_clr;
  logic [RW-1:0]   cic_rate;
  logic [BIN-1:0]  cic_din;
  logic            cic_din_valid;
  logic [BOUT-1:0] cic_dout;
  logic            cic_dout_valid;
  logic [BOUT-1:0] m_data;
  logic            m_valid;
  logic            busy;
  logic            locked;

  cic_dec_ctrl #(
    .N(N), .BIN(BIN), .BOUT(BOUT), .R_MAX(R_MAX), .RW(RW), .FLUSH_CYC(FLUSH_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_rate(cfg_rate), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_err(cfg_err),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .cic_clr(cic_clr), .cic_rate(cic_rate), .cic_din(cic_din), .cic_din_valid(cic_din_valid),
    .cic_dout(cic_dout), .cic_dout_valid(cic_dout_valid),
    .m_data(m_data), .m_valid(m_valid), .busy(busy), .locked(locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int              n_assert;
  int              n_fail;
  int              phase;
  int              flush_left;
  int              disc_left;
  logic [RW-1:0]   exp_rate;
  logic            exp_err;
  logic            exp_mv;
  logic [BOUT-1:0] exp_mdata;
  logic [BOUT-1:0] exp_q[$];
  int              cic_cnt;
  logic            pend;
  int              seq;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    phase      = P_IDLE;
    flush_left = 0;
    disc_left  = 0;
    exp_rate   = '0;
    exp_err    = 1'b0;
    exp_mv     = 1'b0;
    exp_mdata  = '0;
    exp_q.delete();
    cic_cnt    = 0;
    pend       = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cfg_ready"}, 32'(cfg_ready), 32'd1);
    chk({tag, "_cfg_err"},   32'(cfg_err),   32'd0);
    chk({tag, "_s_ready"},   32'(s_ready),   32'd0);
    chk({tag, "_cic_clr"},   32'(cic_clr),   32'd1);
    chk({tag, "_cic_rate"},  32'(cic_rate),  32'd0);
    chk({tag, "_m_valid"},   32'(m_valid),   32'd0);
    chk({tag, "_m_data"},    32'(m_data),    32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_locked"},    32'(locked),    32'd0);
  endtask

  // One clock cycle: inputs are already driven; called and returns at a negedge.
  task automatic step();
    logic          dv;
    logic          clr;
    logic [RW-1:0] rt;
    logic          acc;
    logic          legal;
    logic          nmv;
    int            nphase;
    #1;
    dv  = cic_din_valid;
    clr = cic_clr;
    rt  = cic_rate;
    chk("din_valid", 32'(dv), 32'(s_valid && (phase == P_SETTLE || phase == P_RUN)));
    chk("din", 32'(cic_din), 32'(s_data));
    acc    = cfg_valid && (phase != P_FLUSH);
    legal  = (int'(cfg_rate) >= 2) && (int'(cfg_rate) <= R_MAX);
    nphase = phase;
    nmv    = 1'b0;
    if (phase == P_FLUSH) begin
      flush_left--;
      if (flush_left == 0) begin
        nphase    = P_SETTLE;
        disc_left = N;
      end
    end else if (phase == P_SETTLE && cic_dout_valid) begin
      if (disc_left <= 1) nphase = P_RUN;
      if (disc_left > 0) disc_left--;
    end else if (phase == P_RUN && cic_dout_valid) begin
      exp_q.push_back(cic_dout);
      nmv = 1'b1;
    end
    exp_err = acc && !legal;
    if (acc && legal) begin
      nphase     = P_FLUSH;
      flush_left = FLUSH_CYC;
      exp_rate   = cfg_rate;
    end

    @(posedge clk);
    if (clr) begin
      cic_cnt = 0;
    end else if (dv) begin
      cic_cnt++;
      if (cic_cnt == int'(rt)) begin
        cic_cnt = 0;
        pend    = 1'b1;
      end
    end
    phase  = nphase;
    exp_mv = nmv;

    @(negedge clk);
    chk("cfg_ready", 32'(cfg_ready), 32'(phase != P_FLUSH));
    chk("s_ready",   32'(s_ready),   32'(phase == P_SETTLE || phase == P_RUN));
    chk("cic_clr",   32'(cic_clr),   32'(phase == P_IDLE || phase == P_FLUSH));
    chk("busy",      32'(busy),      32'(phase == P_FLUSH || phase == P_SETTLE));
    chk("locked",    32'(locked),    32'(phase == P_RUN));
    chk("cic_rate",  32'(cic_rate),  32'(exp_rate));
    chk("cfg_err",   32'(cfg_err),   32'(exp_err));
    chk("m_valid",   32'(m_valid),   32'(exp_mv));
    if (m_valid === 1'b1 && exp_q.size() > 0) exp_mdata = exp_q.pop_front();
    chk("m_data", 32'(m_data), 32'(exp_mdata));

    cic_dout_valid = pend;
    if (pend) begin
      cic_dout = BOUT'(32'h5A0000 + seq);
      seq++;
    end
    pend = 1'b0;
    if (dv) s_data = s_data + 1'b1;
  endtask

  task automatic cfg(input int r);
    cfg_rate  = RW'(r);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
  endtask

  // Entered at a negedge: assert reset mid-cycle and check outputs before any clock edge.
  task automatic async_reset(input string tag);
    cfg_valid      = 1'b0;
    s_valid        = 1'b0;
    cic_dout_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs(tag);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_assert       = 0;
    n_fail         = 0;
    seq            = 1;
    rst_n          = 1'b0;
    cfg_rate       = '0;
    cfg_valid      = 1'b0;
    s_data         = '0;
    s_valid        = 1'b0;
    cic_dout       = '0;
    cic_dout_valid = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_reset_outputs("por");
    rst_n = 1'b1;
    repeat (3) step();

    // Cold start at rate 8 with a continuous input stream.
    s_valid = 1'b1;
    cfg(8);
    repeat (100) step();
    chk("cold_locked", 32'(locked), 32'd1);

    // Asynchronous reset from RUN.
    async_reset("rst_run");
    repeat (2) step();

    // Illegal rates in IDLE, including both sides of the legal range.
    cfg(1);
    step();
    cfg(65);
    step();
    cfg(0);
    repeat (2) step();

    // Restart, then change the rate while running.
    s_valid = 1'b1;
    cfg(8);
    repeat (80) step();
    cfg(16);
    repeat (16 * 8) step();

    // Illegal requests while running must not disturb the stream.
    cfg(65);
    cfg(1);
    repeat (40) step();

    // Request held across FLUSH: accepted again once SETTLE re-opens cfg_ready.
    cfg_rate  = RW'(32);
    cfg_valid = 1'b1;
    repeat (6) step();
    cfg_valid = 1'b0;
    repeat (32 * 6) step();

    // Reset after exactly one start-up discard.
    cfg(8);
    for (int i = 0; i < 200; i++) begin
      if (phase == P_SETTLE && disc_left == N - 1) break;
      step();
    end
    chk("settle_reached", 32'({busy, locked, s_ready}), 32'b101);
    async_reset("rst_settle");
    s_valid = 1'b1;
    cfg(8);
    repeat (100) step();

    // Boundary legal rates.
    cfg(64);
    repeat (64 * 5) step();
    cfg(2);
    repeat (30) step();
    s_valid = 1'b0;
    repeat (5) step();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cic_dec_ctrl.md
Name: cic_dec_ctrl

Overview:
- Run-time controller for the CIC decimation filter.
- Accepts decimation-rate configuration requests, flushes the filter on every rate change, and discards the N-sample start-up transient before opening the output.
- Sits between the upstream sample source (valid/ready), the CIC datapath (clear, rate, sample strobe) and the downstream consumer.

Parameters:
- N, 3: CIC stage count; number of post-flush output samples discarded.
- BIN, 12: input sample width.
- BOUT, 24: CIC output width.
- R_MAX, 64: largest legal decimation rate.
- RW, 7: rate field width, $clog2(R_MAX)+1.
- FLUSH_CYC, 4: cycles cic_clr is held after a rate change (>=1).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_rate  in  RW  requested decimation rate
- cfg_valid  in  1  config request
- cfg_ready  out  1  controller can accept config
- cfg_err  out  1  one-cycle pulse: rejected rate
- s_data  in  BIN  upstream sample
- s_valid  in  1  upstream sample valid
- s_ready  out  1  controller accepts samples
- cic_clr  out  1  synchronous clear to the CIC, active-high
- cic_rate  out  RW  decimation rate driven to the CIC
- cic_din  out  BIN  sample to the CIC (= s_data)
- cic_din_valid  out  1  s_valid & s_ready
- cic_dout  in  BOUT  CIC output
- cic_dout_valid  in  1  CIC output strobe
- m_data  out  BOUT  filtered output
- m_valid  out  1  output strobe; no back-pressure
- busy  out  1  state is FLUSH or SETTLE
- locked  out  1  state is RUN

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately and from any state):
  - state=IDLE, cfg_ready=1, cfg_err=0, s_ready=0, cic_clr=1, cic_rate=0.
  - m_data=0, m_valid=0, busy=0, locked=0.
  - Flush and discard counters are cleared.
- Config acceptance:
  - A request is accepted when cfg_valid & cfg_ready.
  - Legal range is 2 <= cfg_rate <= R_MAX.
  - Illegal rate: cfg_err=1 for the next cycle; state, cic_rate and counters are unchanged.
- cfg_ready is 1 in IDLE, SETTLE and RUN, and 0 in FLUSH. All control outputs are registered.
- IDLE:
  - s_ready=0, cic_clr=1.
  - A legal accept latches cic_rate<=cfg_rate on the accept edge and moves to FLUSH.
- FLUSH:
  - cic_clr=1, s_ready=0 for exactly FLUSH_CYC cycles, counted from the first FLUSH cycle.
  - After FLUSH_CYC cycles: SETTLE, with the discard counter loaded with N.
- SETTLE:
  - cic_clr=0, s_ready=1.
  - Each cic_dout_valid decrements the discard counter and is not forwarded.
  - When the N-th strobe is seen, move to RUN; the N-th sample itself is not forwarded.
- RUN:
  - s_ready=1.
  - m_data<=cic_dout and m_valid<=1 one cycle after each cic_dout_valid (latency 1); otherwise m_valid=0 and m_data holds.
- Rate change in SETTLE or RUN:
  - A legal accept re-latches cic_rate and enters FLUSH next cycle.
  - s_ready falls on the same edge; a sample presented in the accept cycle is still handed to the CIC and then cleared.
  - A cic_dout_valid arriving in the accept cycle is still forwarded in RUN.
  - No output is forwarded after that.
- An illegal config in RUN or SETTLE leaves operation unaffected.
- cic_din and cic_din_valid are combinational: cic_din=s_data, cic_din_valid=s_valid&s_ready.
- cic_dout_valid outside SETTLE/RUN is ignored.
- The discard counter saturates at 0.

Test Plan:
1. Reset: pulse rst_n low mid-cycle -> outputs change immediately to cfg_ready=1, cic_clr=1, s_ready=0, cic_rate=0, m_valid=0, m_data=0.
2. Cold start: from IDLE write cfg_rate=8, drive continuous s_valid, with a CIC model strobing every 8 inputs.
   - cic_clr stays high for 4 cycles after the accept; s_ready rises with SETTLE.
   - The first 3 strobes are dropped and locked rises; the 4th strobe appears on m_valid one cycle later with matching m_data.
3. Illegal rates: write 1, then 65, in IDLE -> cfg_err pulses once per write; state stays IDLE; cic_rate stays 0.
4. Rate change in RUN: write 16 while s_valid=1 -> s_ready=0 next cycle, cic_clr high 4 cycles, cic_rate=16, 3 discards, then m_valid resumes at 1/16 of the input rate.
5. Config during FLUSH: hold cfg_valid with 32 from the FLUSH entry -> not accepted until cfg_ready returns in SETTLE; then accepted, FLUSH restarts and cic_rate=32.
6. Reset mid-SETTLE: drop rst_n after 1 discard -> immediate IDLE values; a later cfg 8 again requires 3 fresh discards.
